// File: rtl/elastic_pipe_pkg.sv
// Shared sizing helpers for elastic pipeline buffers and their users.
package pipe_pkg;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Bits needed to address depth entries, never less than one.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// Producer/consumer handshake bundle for elastic_pipe; slave is the buffer's view.
interface elastic_pipe_if #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned DEPTH     = 2
);
  import pipe_pkg::*;

  logic                      flush;
  logic [DATA_SIZE-1:0]      data_i;
  logic                      valid_i;
  logic                      ready_o;
  logic [DATA_SIZE-1:0]      data_o;
  logic                      valid_o;
  logic                      ready_i;
  logic [cnt_w(DEPTH)-1:0]   count_o;
  logic                      afull_o;

  modport master (
    output flush, data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, count_o, afull_o
  );

  modport slave (
    input  flush, data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, count_o, afull_o
  );

endinterface

// File: rtl/elastic_pipe_wrap_ctr.sv
// Modulo-MAX counter with explicit wrap, usable for non-power-of-2 ring pointers.
module wrap_ctr
  import pipe_pkg::*;
#(
  parameter int unsigned MAX = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   inc,
  output logic [ptr_w(MAX)-1:0]  value
);

  localparam int unsigned W = ptr_w(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == W'(MAX - 1)) ? '0 : value + W'(1);
    end
  end

endmodule

// File: rtl/elastic_pipe.sv
// Valid/ready elastic buffer of DEPTH entries with flush, occupancy and almost-full.
// Outputs come only from registered state, except the optional ready pass-through when full.
module elastic_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned DEPTH        = 2,
  parameter bit          PASS_ON_FULL = 1'b0,
  parameter int unsigned AFULL_LVL    = DEPTH - 1
) (
  input logic           clk,
  input logic           rst_n,
  elastic_pipe_if.slave bus
);

  localparam int unsigned CW = cnt_w(DEPTH);

  if (DEPTH < 1 || AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_param_err
    $error("elastic_pipe: DEPTH must be >= 1 and AFULL_LVL within 1..DEPTH");
  end

  logic [CW-1:0]        count;
  logic [DATA_SIZE-1:0] head;
  logic                 full;
  logic                 push;
  logic                 pop;

  assign full        = (count == CW'(DEPTH));
  assign bus.ready_o = !full || (PASS_ON_FULL && bus.ready_i);
  assign bus.valid_o = (count != '0);
  assign bus.data_o  = bus.valid_o ? head : '0;
  assign bus.count_o = count;
  assign bus.afull_o = (count >= CW'(AFULL_LVL));

  assign push = bus.valid_i && bus.ready_o && !bus.flush;
  assign pop  = bus.valid_o && bus.ready_i && !bus.flush;

  // Occupancy tracks push/pop; a simultaneous pair leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.flush) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CW'(1);
    end else if (pop && !push) begin
      count <= count - CW'(1);
    end
  end

  if (DEPTH == 1) begin : g_single
    // A single entry needs no pointers: it is always both head and tail.
    logic [DATA_SIZE-1:0] mem_q;

    always_ff @(posedge clk) begin
      if (push) begin
        mem_q <= bus.data_i;
      end
    end

    assign head = mem_q;
  end else begin : g_ring
    localparam int unsigned PW = ptr_w(DEPTH);

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    wrap_ctr #(.MAX(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .inc   (push),
      .value (wr_ptr)
    );

    wrap_ctr #(.MAX(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (bus.flush),
      .inc   (pop),
      .value (rd_ptr)
    );

    // Storage is deliberately not reset; validity comes from count alone.
    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr] <= bus.data_i;
      end
    end

    assign head = mem[rd_ptr];
  end

endmodule

// File: tb/tb_elastic_pipe.sv
// Directed and randomised checks of elastic_pipe across several DEPTH/PASS_ON_FULL builds.
module tb_elastic_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  elastic_pipe_if #(.DATA_SIZE(32), .DEPTH(4)) i4  ();
  elastic_pipe_if #(.DATA_SIZE(32), .DEPTH(3)) i3  ();
  elastic_pipe_if #(.DATA_SIZE(32), .DEPTH(1)) i1a ();
  elastic_pipe_if #(.DATA_SIZE(32), .DEPTH(1)) i1b ();
  elastic_pipe_if #(.DATA_SIZE(32), .DEPTH(5)) i5  ();

  elastic_pipe #(.DATA_SIZE(32), .DEPTH(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(i4));
  elastic_pipe #(.DATA_SIZE(32), .DEPTH(3)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(i3));
  elastic_pipe #(.DATA_SIZE(32), .DEPTH(1), .PASS_ON_FULL(1'b0), .AFULL_LVL(1))
    u_d1a (.clk(clk), .rst_n(rst_n), .bus(i1a));
  elastic_pipe #(.DATA_SIZE(32), .DEPTH(1), .PASS_ON_FULL(1'b1), .AFULL_LVL(1))
    u_d1b (.clk(clk), .rst_n(rst_n), .bus(i1b));
  elastic_pipe #(.DATA_SIZE(32), .DEPTH(5), .PASS_ON_FULL(1'b1), .AFULL_LVL(4))
    u_d5 (.clk(clk), .rst_n(rst_n), .bus(i5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] vals [4];
    logic [31:0] q [$];
    logic [31:0] nin_a, nout_a, nin_b, nout_b;
    int          pops_a, pops_b, beats, cyc;
    logic        push_a, push_b, do_push, did_rst;

    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
    {i4.flush, i4.valid_i, i4.ready_i, i4.data_i}     = '0;
    {i3.flush, i3.valid_i, i3.ready_i, i3.data_i}     = '0;
    {i1a.flush, i1a.valid_i, i1a.ready_i, i1a.data_i} = '0;
    {i1b.flush, i1b.valid_i, i1b.ready_i, i1b.data_i} = '0;
    {i5.flush, i5.valid_i, i5.ready_i, i5.data_i}     = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Reset then idle
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("idle_valid", 32'(i4.valid_o), 32'd0);
      chk("idle_data",  i4.data_o,       32'd0);
      chk("idle_count", 32'(i4.count_o), 32'd0);
      chk("idle_ready", 32'(i4.ready_o), 32'd1);
      chk("idle_afull", 32'(i4.afull_o), 32'd0);
      tick();
    end

    // Fill DEPTH=4 with consumer stalled
    i4.ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i4.valid_i = 1'b1;
      i4.data_i  = vals[k];
      tick();
      chk("fill_count", 32'(i4.count_o), 32'(k + 1));
      chk("fill_afull", 32'(i4.afull_o), 32'((k + 1) >= 3));
      chk("fill_ready", 32'(i4.ready_o), 32'((k + 1) < 4));
      chk("fill_head",  i4.data_o,       32'h11);
    end
    i4.data_i = 32'h55;
    #1;
    chk("full_ready", 32'(i4.ready_o), 32'd0);
    tick();
    chk("full_count", 32'(i4.count_o), 32'd4);
    chk("full_head",  i4.data_o,       32'h11);
    i4.valid_i = 1'b0;
    i4.ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("drain_valid", 32'(i4.valid_o), 32'd1);
      chk("drain_data",  i4.data_o,       vals[k]);
      tick();
    end
    #1;
    chk("drained_valid", 32'(i4.valid_o), 32'd0);
    chk("drained_count", 32'(i4.count_o), 32'd0);
    chk("drained_data",  i4.data_o,       32'd0);
    i4.ready_i = 1'b0;
    tick();

    // DEPTH=3 streaming 1..20
    i3.ready_i = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) begin
        i3.valid_i = 1'b1;
        i3.data_i  = 32'(c + 1);
      end else begin
        i3.valid_i = 1'b0;
      end
      #1;
      if (c == 0) begin
        chk("stream_first_valid", 32'(i3.valid_o), 32'd0);
      end else begin
        chk("stream_valid", 32'(i3.valid_o), 32'd1);
        chk("stream_data",  i3.data_o,       32'(c));
        chk("stream_count", 32'(i3.count_o), 32'd1);
      end
      tick();
    end
    #1;
    chk("stream_end_count", 32'(i3.count_o), 32'd0);
    i3.ready_i = 1'b0;
    tick();

    // DEPTH=1 throughput, PASS_ON_FULL off vs on, over 20 cycles
    nin_a = 32'd1; nout_a = 32'd1; nin_b = 32'd1; nout_b = 32'd1;
    pops_a = 0; pops_b = 0;
    i1a.ready_i = 1'b1; i1b.ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      i1a.valid_i = 1'b1; i1a.data_i = nin_a;
      i1b.valid_i = 1'b1; i1b.data_i = nin_b;
      #1;
      push_a = i1a.ready_o;
      push_b = i1b.ready_o;
      if (i1a.valid_o) begin
        chk("d1_nopass_data", i1a.data_o, nout_a);
        nout_a++;
        pops_a++;
      end
      if (i1b.valid_o) begin
        chk("d1_pass_data", i1b.data_o, nout_b);
        nout_b++;
        pops_b++;
      end
      tick();
      if (push_a) nin_a++;
      if (push_b) nin_b++;
    end
    chk("d1_nopass_beats", 32'(pops_a), 32'd10);
    chk("d1_pass_beats",   32'(pops_b), 32'd19);
    i1a.valid_i = 1'b0; i1b.valid_i = 1'b0;
    i1a.ready_i = 1'b0; i1b.ready_i = 1'b0;
    tick();

    // Flush with simultaneous push and pop
    for (int k = 0; k < 3; k++) begin
      i4.valid_i = 1'b1;
      i4.data_i  = 32'hA1 + 32'(k);
      tick();
    end
    chk("pre_flush_count", 32'(i4.count_o), 32'd3);
    i4.flush = 1'b1; i4.valid_i = 1'b1; i4.ready_i = 1'b1; i4.data_i = 32'hB0;
    tick();
    i4.flush = 1'b0; i4.valid_i = 1'b0; i4.ready_i = 1'b0;
    #1;
    chk("flush_count", 32'(i4.count_o), 32'd0);
    chk("flush_valid", 32'(i4.valid_o), 32'd0);
    chk("flush_data",  i4.data_o,       32'd0);
    i4.valid_i = 1'b1; i4.data_i = 32'hC0;
    tick();
    i4.valid_i = 1'b0;
    #1;
    chk("post_flush_valid", 32'(i4.valid_o), 32'd1);
    chk("post_flush_data",  i4.data_o,       32'hC0);
    chk("post_flush_count", 32'(i4.count_o), 32'd1);
    i4.ready_i = 1'b1;
    tick();
    i4.ready_i = 1'b0;
    #1;
    chk("post_flush_drain", 32'(i4.count_o), 32'd0);
    tick();

    // Random traffic on DEPTH=5 with a mid-run reset
    beats = 0;
    cyc = 0;
    did_rst = 1'b0;
    while (beats < 10000 && cyc < 50000) begin
      cyc++;
      if (beats == 5000 && !did_rst) begin
        did_rst = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(i5.valid_o), 32'd0);
        chk("rst_count", 32'(i5.count_o), 32'd0);
        chk("rst_data",  i5.data_o,       32'd0);
        chk("rst_afull", 32'(i5.afull_o), 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        continue;
      end
      i5.valid_i = 1'($urandom_range(0, 1));
      i5.ready_i = 1'($urandom_range(0, 1));
      i5.data_i  = $urandom;
      #1;
      chk("rnd_count", 32'(i5.count_o), 32'(q.size()));
      chk("rnd_afull", 32'(i5.afull_o), 32'(q.size() >= 4));
      do_push = i5.valid_i && i5.ready_o;
      if (i5.valid_o && i5.ready_i) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_pop", 32'd1, 32'd0);
        end else begin
          chk("rnd_data", i5.data_o, q.pop_front());
        end
        beats++;
      end
      if (do_push) q.push_back(i5.data_i);
      tick();
    end
    chk("rnd_beats", 32'(beats), 32'd10000);
    chk("rnd_did_reset", 32'(did_rst), 32'd1);
    i5.valid_i = 1'b0;
    i5.ready_i = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
